// File: rtl/prog_ctr_pkg.sv
// Shared widths and jump base table for the program counter.
package prog_ctr_pkg;
  localparam int PC_W  = 10;
  localparam int OFF_W = 8;

  localparam logic [PC_W-1:0] BASE0 = 10'd0;
  localparam logic [PC_W-1:0] BASE1 = 10'd256;
  localparam logic [PC_W-1:0] BASE2 = 10'd512;
  localparam logic [PC_W-1:0] BASE3 = 10'd768;

  function automatic logic [PC_W-1:0] base_sel(input logic [1:0] sel);
    case (sel)
      2'd0:    base_sel = BASE0;
      2'd1:    base_sel = BASE1;
      2'd2:    base_sel = BASE2;
      default: base_sel = BASE3;
    endcase
  endfunction
endpackage

// File: rtl/prog_ctr_target.sv
// Branch target: selected base plus zero-extended offset, wrapping at PC width.
module prog_ctr_target
  import prog_ctr_pkg::*;
(
  input  logic [1:0]       PCRegAddr,
  input  logic [OFF_W-1:0] offset,
  output logic [PC_W-1:0]  target
);
  assign target = base_sel(PCRegAddr) + {{(PC_W-OFF_W){1'b0}}, offset};
endmodule

// File: rtl/prog_ctr.sv
// Program counter: restart, conditional branch to base+offset, else increment.
module prog_ctr
  import prog_ctr_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             JmpEq,
  input  logic             JmpNe,
  input  logic             Zero,
  input  logic             OffsetEn,
  input  logic [1:0]       PCRegAddr,
  input  logic [OFF_W-1:0] offset,
  output logic [PC_W-1:0]  ProgCtr
);
  logic [PC_W-1:0] pc, pc_nxt, target;
  logic            take;

  prog_ctr_target u_target (
    .PCRegAddr (PCRegAddr),
    .offset    (offset),
    .target    (target)
  );

  // OffsetEn qualifies every branch, so held flags never re-branch on their own.
  assign take = OffsetEn & ((JmpEq & Zero) | (JmpNe & ~Zero));

  always_comb begin
    pc_nxt = pc + 1'b1;
    if (Start)     pc_nxt = '0;
    else if (take) pc_nxt = target;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) pc <= '0;
    else        pc <= pc_nxt;
  end

  assign ProgCtr = pc;
endmodule

// File: tb/tb_prog_ctr.sv
// Directed bench for prog_ctr: reset, branches, conditions, wrap, restart, async reset.
module tb_prog_ctr;
  logic       Clk, Reset, Start, JmpEq, JmpNe, Zero, OffsetEn;
  logic [1:0] PCRegAddr;
  logic [7:0] offset;
  logic [9:0] ProgCtr;

  int errors = 0;
  int checks = 0;

  prog_ctr dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .JmpEq     (JmpEq),
    .JmpNe     (JmpNe),
    .Zero      (Zero),
    .OffsetEn  (OffsetEn),
    .PCRegAddr (PCRegAddr),
    .offset    (offset),
    .ProgCtr   (ProgCtr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] exp);
    checks++;
    assert (ProgCtr === exp)
    else begin
      errors++;
      $error("FAIL %s: ProgCtr=%0d expected=%0d", tag, ProgCtr, exp);
    end
  endtask

  task automatic idle();
    Start = 0; JmpEq = 0; JmpNe = 0; Zero = 0; OffsetEn = 0;
    PCRegAddr = 2'd0; offset = 8'd0;
  endtask

  task automatic br(input logic eq, input logic ne, input logic z,
                    input logic [1:0] a, input logic [7:0] off);
    JmpEq = eq; JmpNe = ne; Zero = z; OffsetEn = 1; PCRegAddr = a; offset = off;
  endtask

  initial begin
    idle();
    Reset = 0;
    // Inputs toggled during reset must be ignored.
    #2; br(1, 1, 1, 2'd3, 8'd9); Start = 0;
    step(); step(); step();
    chk("reset_hold", 10'd0);

    idle();
    Reset = 1;
    step(); chk("first_edge", 10'd1);
    step(); step(); step(); step();
    chk("count5", 10'd5);

    Start = 1; step(); chk("start", 10'd0);
    Start = 0; step(); step(); chk("pc2", 10'd2);

    br(1, 0, 1, 2'd1, 8'd100); step(); chk("jmpeq_356", 10'd356);
    OffsetEn = 0; step(); chk("held_357", 10'd357);
    step(); chk("held_358", 10'd358);

    br(0, 1, 0, 2'd2, 8'd25); step(); chk("jmpne_537", 10'd537);

    br(0, 1, 0, 2'd0, 8'd40); step(); chk("pc40", 10'd40);
    br(1, 0, 0, 2'd1, 8'd100); step(); chk("eq_nottaken", 10'd41);
    br(0, 1, 1, 2'd1, 8'd100); step(); chk("ne_nottaken", 10'd42);

    br(1, 1, 0, 2'd1, 8'd3); step(); chk("both_z0", 10'd259);
    br(1, 1, 1, 2'd0, 8'd77); step(); chk("both_z1_77", 10'd77);

    br(1, 0, 1, 2'd3, 8'd255); Start = 1; step(); chk("start_over_take", 10'd0);
    Start = 0; step(); chk("target_1023", 10'd1023);
    idle(); step(); chk("wrap_0", 10'd0);
    step(); step(); chk("pc2_again", 10'd2);

    // Reset mid-branch, between edges.
    br(1, 0, 1, 2'd2, 8'd7);
    #2; Reset = 0; #1;
    chk("async_reset", 10'd0);
    step(); chk("reset_over_branch", 10'd0);
    idle(); Reset = 1;
    step(); chk("post_reset", 10'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_ctr.md
PROG_CTR -- requirements
Module: prog_ctr

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset SHALL exist.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-low reset; PC cleared while low.
REQ-004 Start  input  1  synchronous restart request; forces PC to 0.
REQ-005 JmpEq  input  1  branch-if-equal request; condition is Zero=1.
REQ-006 JmpNe  input  1  branch-if-not-equal request; condition is Zero=0.
REQ-007 Zero  input  1  ALU zero/equality flag.
REQ-008 OffsetEn  input  1  branch enable, one-cycle qualifier; no branch is taken while low.
REQ-009 PCRegAddr  input  2  selects one of four jump base addresses.
REQ-010 offset  input  8  unsigned offset added to the selected base.
REQ-011 ProgCtr  output  10  current program counter, registered.

Function
REQ-012 Per rising Clk edge, the next PC SHALL be chosen by priority: Start, then taken branch, then increment.
REQ-013 Start=1: PC SHALL become 0 at the next edge, regardless of branch inputs.
REQ-014 take = OffsetEn AND ((JmpEq AND Zero) OR (JmpNe AND NOT Zero)).
REQ-015 take=1: PC SHALL become (BASE[PCRegAddr] + zero-extended offset) mod 1024 at the next edge.
REQ-016 BASE SHALL be {0, 256, 512, 768} for PCRegAddr = 00, 01, 10, 11.
REQ-017 take=0 and Start=0: PC SHALL become (PC + 1) mod 1024; 1023 wraps to 0.
REQ-018 JmpEq and JmpNe both high with OffsetEn=1: the branch SHALL be taken regardless of Zero.
REQ-019 JmpEq/JmpNe/Zero held high with OffsetEn=0: the PC SHALL increment normally with no repeat branching.
REQ-020 Branch latency SHALL be one cycle: the target appears on ProgCtr on the edge that samples take=1.
REQ-021 ProgCtr SHALL be driven directly from the PC register, with no combinational path from inputs to output.

Reset
REQ-022 Reset low SHALL force ProgCtr to 0 immediately, without waiting for a clock edge.
REQ-023 While Reset is low, all other inputs SHALL be ignored.
REQ-024 After Reset rises, the first rising edge SHALL apply REQ-012 normally (0 -> 1 if idle).
REQ-025 Reset asserted mid-branch SHALL override the branch; PC is 0.

Structure
REQ-026 A shared package prog_ctr_pkg SHALL hold PC_W=10, OFF_W=8, and the four BASE constants.
REQ-027 One sub-module, prog_ctr_target, SHALL compute the branch target combinationally from PCRegAddr and offset.
REQ-028 The top SHALL contain only the take logic, the next-PC mux and the PC register.

Verification
REQ-029 Reset low, clock running -> ProgCtr=0; release Reset, 5 edges -> ProgCtr=5.
REQ-030 PC=2; JmpEq=1, Zero=1, OffsetEn=1, PCRegAddr=01, offset=100 for one cycle -> next ProgCtr=356; then 357, 358 with JmpEq/Zero still high and OffsetEn=0.
REQ-031 JmpNe=1, Zero=0, OffsetEn=1, PCRegAddr=10, offset=25 -> next ProgCtr=537.
REQ-032 JmpEq=1, Zero=0, OffsetEn=1 from PC=40 -> not taken, ProgCtr=41; JmpNe=1, Zero=1 -> also not taken.
REQ-033 PCRegAddr=11, offset=255, take=1 -> ProgCtr=1023; next idle edge -> 0 (wrap).
REQ-034 Start=1 together with take=1 at PC=77 -> ProgCtr=0; Reset pulsed low between edges -> ProgCtr=0 asynchronously.
